// File: rtl/prbs_pkg.sv
// Shared types and constants for the PRBS word source.
// Imported by the generator top; the FIFO is type-agnostic.
package prbs_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef enum logic {
      MODE_CONT  = 1'b0,
      MODE_BURST = 1'b1
   } mode_t;

   localparam logic [7:0] DEFAULT_POLY_8 = 8'hB8;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO; pointers carry an extra wrap bit.
// The head word is read straight from the array so it is valid while non-empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             do_push, do_pop;

   always_comb begin
      empty    = (wr_ptr_q == rd_ptr_q);
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      level    = wr_ptr_q - rd_ptr_q;
      // A pop never happens on an empty FIFO, so a word cannot bypass in one cycle.
      do_pop   = pop && !empty;
      do_push  = push && (!full || do_pop);
      wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      head_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_data;
      end
   end

endmodule

// File: rtl/prbs_stream_gen.sv
// Galois-LFSR word source: unrolled LFSR, LSB-first packer, run-control FSM and
// status counters feeding a FWFT FIFO drained over valid/ready.
module prbs_stream_gen
   import prbs_pkg::*;
#(
   parameter int                     LFSR_WIDTH     = 8,
   parameter int unsigned            LFSR_SEED      = 1,
   parameter logic [LFSR_WIDTH-1:0]  LFSR_POLY      = DEFAULT_POLY_8,
   parameter int                     BITS_PER_CLOCK = 1,
   parameter int                     FIFO_WIDTH     = 8,
   parameter int                     FIFO_DEPTH     = 16,
   parameter int                     COUNT_WIDTH    = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic                           stop,
   input  logic                           mode,
   input  logic [COUNT_WIDTH-1:0]         burst_len,
   input  logic                           reseed,
   input  logic                           out_ready,
   output logic [FIFO_WIDTH-1:0]          out_data,
   output logic                           out_valid,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_level,
   output logic                           fifo_full,
   output logic                           fifo_empty,
   output logic                           busy,
   output logic                           done,
   output logic [COUNT_WIDTH-1:0]         word_count
);

   localparam int WORD_CYC = FIFO_WIDTH / BITS_PER_CLOCK;
   localparam int CNT_W    = (WORD_CYC > 1) ? $clog2(WORD_CYC) : 1;
   localparam logic [LFSR_WIDTH-1:0] SEED = LFSR_WIDTH'(LFSR_SEED);

   if (SEED == '0) begin : g_bad_seed
      $error("prbs_stream_gen: LFSR_SEED must be nonzero");
   end
   if (LFSR_WIDTH < 2) begin : g_bad_width
      $error("prbs_stream_gen: LFSR_WIDTH must be at least 2");
   end
   if ((FIFO_WIDTH % BITS_PER_CLOCK) != 0) begin : g_bad_bpc
      $error("prbs_stream_gen: FIFO_WIDTH must be a multiple of BITS_PER_CLOCK");
   end
   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("prbs_stream_gen: FIFO_DEPTH must be a power of two");
   end

   state_t                  state_q, state_d;
   mode_t                   mode_q, mode_d;
   logic [LFSR_WIDTH-1:0]   lfsr_q, lfsr_d, lfsr_adv;
   logic [FIFO_WIDTH-1:0]   pack_q, pack_d, pack_word;
   logic [CNT_W-1:0]        pack_cnt_q, pack_cnt_d;
   logic [COUNT_WIDTH-1:0]  words_left_q, words_left_d;
   logic [COUNT_WIDTH-1:0]  word_count_q, word_count_d;
   logic                    done_q, done_d;
   logic [BITS_PER_CLOCK-1:0] step_bits;
   logic                    word_complete, push_ok, stall, fifo_push, fifo_pop;

   // Unrolled LFSR: bit i of step_bits is the i-th output bit this cycle.
   always_comb begin
      lfsr_adv  = lfsr_q;
      step_bits = '0;
      for (int i = 0; i < BITS_PER_CLOCK; i++) begin
         step_bits[i] = lfsr_adv[0];
         lfsr_adv     = (lfsr_adv >> 1) ^ (lfsr_adv[0] ? LFSR_POLY : '0);
      end
   end

   always_comb begin
      pack_word = pack_q;
      pack_word[int'(pack_cnt_q) * BITS_PER_CLOCK +: BITS_PER_CLOCK] = step_bits;
      word_complete = (pack_cnt_q == CNT_W'(WORD_CYC - 1));
      fifo_pop  = out_valid && out_ready;
      push_ok   = !fifo_full || fifo_pop;
      stall     = word_complete && !push_ok;
   end

   always_comb begin
      state_d      = state_q;
      mode_d       = mode_q;
      lfsr_d       = lfsr_q;
      pack_d       = pack_q;
      pack_cnt_d   = pack_cnt_q;
      words_left_d = words_left_q;
      word_count_d = word_count_q;
      done_d       = 1'b0;
      fifo_push    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (reseed) begin
               lfsr_d = SEED;
            end
            if (start && !stop) begin
               word_count_d = '0;
               mode_d       = mode ? MODE_BURST : MODE_CONT;
               words_left_d = burst_len;
               pack_d       = '0;
               pack_cnt_d   = '0;
               if (mode && burst_len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (stop) begin
               // Partial word is dropped; the LFSR keeps its position for a resume.
               state_d    = IDLE;
               pack_d     = '0;
               pack_cnt_d = '0;
            end else if (!stall) begin
               lfsr_d = lfsr_adv;
               if (word_complete) begin
                  fifo_push    = 1'b1;
                  pack_d       = '0;
                  pack_cnt_d   = '0;
                  word_count_d = word_count_q + 1'b1;
                  if (mode_q == MODE_BURST) begin
                     words_left_d = words_left_q - 1'b1;
                     if (words_left_q == COUNT_WIDTH'(1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                     end
                  end
               end else begin
                  pack_d     = pack_word;
                  pack_cnt_d = pack_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         mode_q       <= MODE_CONT;
         lfsr_q       <= SEED;
         pack_q       <= '0;
         pack_cnt_q   <= '0;
         words_left_q <= '0;
         word_count_q <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         lfsr_q       <= lfsr_d;
         pack_q       <= pack_d;
         pack_cnt_q   <= pack_cnt_d;
         words_left_q <= words_left_d;
         word_count_q <= word_count_d;
         done_q       <= done_d;
      end
   end

   sync_fifo #(
      .WIDTH (FIFO_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (pack_word),
      .pop       (fifo_pop),
      .head_data (out_data),
      .level     (fifo_level),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign out_valid  = !fifo_empty;
   assign busy       = (state_q == RUN);
   assign done       = done_q;
   assign word_count = word_count_q;

endmodule

// File: tb/tb_prbs_stream_gen.sv
// Directed bench for prbs_stream_gen: a reference LFSR model feeds a scoreboard queue
// that is compared against words popped from the stream port.
module tb_prbs_stream_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        a_start, a_stop, a_mode, a_reseed, a_ready;
   logic [15:0] a_burst_len;
   logic [7:0]  a_data;
   logic        a_valid, a_full, a_empty, a_busy, a_done;
   logic [4:0]  a_level;
   logic [15:0] a_wc;

   logic        b_start, b_stop, b_mode, b_reseed, b_ready;
   logic [15:0] b_burst_len;
   logic [7:0]  b_data;
   logic        b_valid, b_full, b_empty, b_busy, b_done;
   logic [4:0]  b_level;
   logic [15:0] b_wc;

   prbs_stream_gen dut_a (
      .clk(clk), .reset(reset), .start(a_start), .stop(a_stop), .mode(a_mode),
      .burst_len(a_burst_len), .reseed(a_reseed), .out_ready(a_ready),
      .out_data(a_data), .out_valid(a_valid), .fifo_level(a_level), .fifo_full(a_full),
      .fifo_empty(a_empty), .busy(a_busy), .done(a_done), .word_count(a_wc)
   );

   prbs_stream_gen #(.BITS_PER_CLOCK(8)) dut_b (
      .clk(clk), .reset(reset), .start(b_start), .stop(b_stop), .mode(b_mode),
      .burst_len(b_burst_len), .reseed(b_reseed), .out_ready(b_ready),
      .out_data(b_data), .out_valid(b_valid), .fifo_level(b_level), .fifo_full(b_full),
      .fifo_empty(b_empty), .busy(b_busy), .done(b_done), .word_count(b_wc)
   );

   int         checks = 0;
   int         failures = 0;
   logic [7:0] exp_q[$];
   logic [7:0] m_lfsr, m_tmp, m_frozen, m_w;

   function automatic logic [7:0] model_step(input logic [7:0] s);
      return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
   endfunction

   function automatic logic [7:0] model_word(input logic [7:0] s_in, output logic [7:0] s_out);
      logic [7:0] s = s_in;
      logic [7:0] w = '0;
      for (int i = 0; i < 8; i++) begin
         w[i] = s[0];
         s    = model_step(s);
      end
      s_out = s;
      return w;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Pops dut_a words against the scoreboard until it empties or the budget runs out.
   task automatic drain_a(input string tag, input int max_cycles);
      int n = 0;
      a_ready = 1'b1;
      while (exp_q.size() > 0 && n < max_cycles) begin
         if (a_valid) begin
            check(tag, a_data, exp_q.pop_front());
         end
         tick();
         n++;
      end
      if (exp_q.size() != 0) begin
         check({tag, "_timeout"}, exp_q.size(), 0);
         exp_q.delete();
      end
      a_ready = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      reset = 1'b1;
      {a_start, a_stop, a_mode, a_reseed, a_ready} = '0;
      {b_start, b_stop, b_mode, b_reseed, b_ready} = '0;
      a_burst_len = '0;
      b_burst_len = '0;
      tick(); tick();
      reset = 1'b0;
      tick();

      check("rst_valid", a_valid, 0);
      check("rst_busy", a_busy, 0);
      check("rst_done", a_done, 0);
      check("rst_level", a_level, 0);
      check("rst_empty", a_empty, 1);
      check("rst_full", a_full, 0);
      check("rst_data", a_data, 0);
      check("rst_wc", a_wc, 0);
      check("rst_lfsr", dut_a.lfsr_q, 8'h01);

      // Single-word burst from the seed.
      m_lfsr = 8'h01;
      m_w = model_word(m_lfsr, m_lfsr);
      exp_q.push_back(m_w);
      a_mode = 1'b1; a_burst_len = 16'd1; a_ready = 1'b1; a_start = 1'b1;
      tick();
      a_start = 1'b0;
      n = 0;
      while (!a_valid && n < 20) begin tick(); n++; end
      check("t1_latency", n, 8);
      check("t1_word_literal", a_data, 8'h71);
      check("t1_done", a_done, 1);
      check("t1_busy", a_busy, 0);
      check("t1_wc", a_wc, 1);
      check("t1_lfsr", dut_a.lfsr_q, 8'h64);
      drain_a("t1_word", 5);
      check("t1_done_pulse", a_done, 0);

      // Zero-length burst: done pulse, no run, no words.
      a_mode = 1'b1; a_burst_len = 16'd0; a_start = 1'b1;
      tick();
      a_start = 1'b0;
      check("bl0_done", a_done, 1);
      check("bl0_busy", a_busy, 0);
      check("bl0_wc", a_wc, 0);
      tick();
      check("bl0_level", a_level, 0);
      check("bl0_done_pulse", a_done, 0);

      // Eight bits per clock: one word per RUN cycle, same sequence.
      m_tmp = 8'h01;
      b_mode = 1'b1; b_burst_len = 16'd3; b_ready = 1'b1; b_start = 1'b1;
      tick();
      b_start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         m_w = model_word(m_tmp, m_tmp);
         check("t2_valid", b_valid, 1);
         check("t2_word", b_data, m_w);
      end
      check("t2_done", b_done, 1);
      check("t2_busy", b_busy, 0);
      check("t2_wc", b_wc, 3);
      tick();
      b_ready = 1'b0;
      check("t2_empty", b_empty, 1);

      // Continuous run into a blocked consumer: fill, then freeze.
      for (int k = 0; k < 17; k++) begin
         m_w = model_word(m_lfsr, m_lfsr);
         exp_q.push_back(m_w);
         if (k == 15) begin
            m_frozen = m_lfsr;
            for (int j = 0; j < 7; j++) m_frozen = model_step(m_frozen);
         end
      end
      a_mode = 1'b0; a_ready = 1'b0; a_start = 1'b1;
      tick();
      a_start = 1'b0;
      n = 0;
      while (!a_full && n < 200) begin tick(); n++; end
      check("t3_full", a_full, 1);
      check("t3_level", a_level, 16);
      for (int k = 0; k < 10; k++) tick();
      check("t3_lfsr_frozen", dut_a.lfsr_q, m_frozen);
      check("t3_busy", a_busy, 1);

      // Pop while full with a word waiting: push accepted, level holds.
      a_ready = 1'b1;
      check("t4_pop_word", a_data, exp_q.pop_front());
      tick();
      a_ready = 1'b0;
      check("t4_level", a_level, 16);
      check("t4_full", a_full, 1);
      a_stop = 1'b1;
      tick();
      a_stop = 1'b0;
      check("t4_busy", a_busy, 0);
      check("t4_lfsr", dut_a.lfsr_q, m_lfsr);
      check("t4_wc", a_wc, 17);
      drain_a("t3_drain", 60);
      check("t3_empty", a_empty, 1);

      // Stop after four steps into a word; nothing is pushed.
      a_mode = 1'b0; a_ready = 1'b1; a_start = 1'b1;
      tick();
      a_start = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      a_stop = 1'b1;
      tick();
      a_stop = 1'b0;
      for (int j = 0; j < 4; j++) m_lfsr = model_step(m_lfsr);
      check("t5_busy", a_busy, 0);
      check("t5_level", a_level, 0);
      check("t5_wc", a_wc, 0);
      check("t5_lfsr_mid", dut_a.lfsr_q, m_lfsr);

      // Resume from mid-state; a reseed pulse during RUN must be ignored.
      for (int k = 0; k < 2; k++) begin
         m_w = model_word(m_lfsr, m_lfsr);
         exp_q.push_back(m_w);
      end
      a_mode = 1'b1; a_burst_len = 16'd2; a_start = 1'b1;
      tick();
      a_start = 1'b0;
      a_reseed = 1'b1;
      tick();
      a_reseed = 1'b0;
      drain_a("t5_resume", 40);
      check("t5_resume_busy", a_busy, 0);
      check("t5_resume_wc", a_wc, 2);

      a_reseed = 1'b1;
      tick();
      a_reseed = 1'b0;
      check("t5_reseed_lfsr", dut_a.lfsr_q, 8'h01);
      m_lfsr = 8'h01;
      m_w = model_word(m_lfsr, m_lfsr);
      exp_q.push_back(m_w);
      a_mode = 1'b1; a_burst_len = 16'd1; a_start = 1'b1;
      tick();
      a_start = 1'b0;
      drain_a("t5_reseed_word", 30);

      // Reset in RUN with five words held.
      a_mode = 1'b0; a_ready = 1'b0; a_start = 1'b1;
      tick();
      a_start = 1'b0;
      n = 0;
      while (a_level != 5'd5 && n < 100) begin tick(); n++; end
      check("t6_level_pre", a_level, 5);
      reset = 1'b1;
      tick();
      check("t6_level", a_level, 0);
      check("t6_valid", a_valid, 0);
      check("t6_busy", a_busy, 0);
      check("t6_lfsr", dut_a.lfsr_q, 8'h01);
      check("t6_empty", a_empty, 1);
      check("t6_data", a_data, 0);
      check("t6_wc", a_wc, 0);
      reset = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
